input_buffer_mc: RTL and testbench

//  Parametrised, flow-controlled input queue at the head of the trace pipeline.

---
 rtl/input_buffer_mc.sv | 173 +++++++++++++++++
 tb/tb_input_buffer_mc.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_mc.sv
// rtl/input_buffer_mc.sv - flow-controlled input queue with chain id tagging
//
// Purpose:
//   Holds up to IB_DEPTH vectors of N x DATA_WIDTH, each stored with its EOF bit.
//   The storage is a dual-port RAM with a registered read port, followed by one
//   output register that drives a valid/ready interface. Every output entry is
//   tagged with a round-robin chain id. The id advances when an EOF entry leaves.
//   Enqueues that arrive while the queue is full are dropped. A dropped enqueue
//   sets a sticky overflow flag and is never written over stored data.
//
// Optional feature:
//   INPUT_BUFFER_DROP_COUNT_EN - when defined, drop_count is a 16-bit saturating
//   count of dropped enqueues. When undefined, drop_count is tied to zero.
//
// Ports:
//   clk, rst_n     clock (rising edge) and async active-low reset
//   enqueue        write vector_in/eof_in this cycle (accepted iff ready_out)
//   eof_in         end-of-frame marker for vector_in
//   vector_in      input vector, N lanes of DATA_WIDTH
//   ready_out      queue not full (from registered occupancy)
//   deq_ready      downstream accepts the output entry this cycle
//   valid_out      vector_out/eof_out/chainId_out hold a valid entry
//   eof_out        EOF bit stored with the output entry
//   vector_out     output vector
//   chainId_out    chain id of the output entry
//   occupancy      entries held, counting the read stage and the output register
//   overflow       sticky: an enqueue was dropped (cleared only by reset)
//   drop_count     number of dropped enqueues
module input_buffer_mc #(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int IB_DEPTH   = 4,
   parameter int NUM_CHAINS = 2,
   localparam int CW        = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1,
   localparam int OW        = $clog2(IB_DEPTH + 1)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               enqueue,
   input  logic                               eof_in,
   input  logic [N-1:0][DATA_WIDTH-1:0]       vector_in,
   output logic                               ready_out,
   input  logic                               deq_ready,
   output logic                               valid_out,
   output logic                               eof_out,
   output logic [N-1:0][DATA_WIDTH-1:0]       vector_out,
   output logic [CW-1:0]                      chainId_out,
   output logic [OW-1:0]                      occupancy,
   output logic                               overflow,
   output logic [15:0]                        drop_count
);

   localparam int WW = N * DATA_WIDTH + 1;
   localparam int PW = $clog2(IB_DEPTH);
   localparam logic [PW-1:0] PTR_LAST   = PW'(IB_DEPTH - 1);
   localparam logic [OW-1:0] DEPTH_C    = OW'(IB_DEPTH);
   localparam logic [CW-1:0] CHAIN_LAST = CW'(NUM_CHAINS - 1);

   logic [WW-1:0] mem_q [IB_DEPTH];
   logic [WW-1:0] rd_data_q;
   logic [WW-1:0] wr_data_d;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] ram_cnt_q, ram_cnt_d;   // entries written but not yet read
   logic [OW-1:0] occ_q, occ_d;           // entries anywhere in the block
   logic          s1_valid_q, s1_valid_d; // rd_data_q holds an entry
   logic          valid_q, valid_d;
   logic [WW-1:0] out_q, out_d;
   logic [CW-1:0] chain_q, chain_d;
   logic          ovf_q, ovf_d;

   logic ready, accept, drop, xfer, load_out, do_read;

   always_comb begin
      ready     = (occ_q < DEPTH_C);
      accept    = enqueue && ready;
      drop      = enqueue && !ready;
      xfer      = valid_q && deq_ready;
      // The read stage empties into the output register when that register is
      // empty or leaving; the RAM is read whenever the read stage will be free.
      // This gives one entry per cycle in steady state with no bubbles.
      load_out  = s1_valid_q && (!valid_q || deq_ready);
      do_read   = (ram_cnt_q != '0) && (!s1_valid_q || load_out);
      wr_data_d = {eof_in, vector_in};

      wr_ptr_d = wr_ptr_q;
      if (accept) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      rd_ptr_d = rd_ptr_q;
      if (do_read) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);

      ram_cnt_d = ram_cnt_q;
      case ({accept, do_read})
         2'b10:   ram_cnt_d = ram_cnt_q + OW'(1);
         2'b01:   ram_cnt_d = ram_cnt_q - OW'(1);
         default: ram_cnt_d = ram_cnt_q;
      endcase

      occ_d = occ_q;
      case ({accept, xfer})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase

      s1_valid_d = do_read || (s1_valid_q && !load_out);
      valid_d    = load_out || (valid_q && !deq_ready);
      out_d      = load_out ? rd_data_q : out_q;

      chain_d = chain_q;
      if (xfer && out_q[WW-1]) chain_d = (chain_q == CHAIN_LAST) ? '0 : chain_q + CW'(1);

      ovf_d = ovf_q || drop;
   end

   // RAM: no reset, writes only on accept. A read never targets the slot being
   // written because reads require ram_cnt_q > 0 and writes require not-full.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= wr_data_d;
      if (do_read) rd_data_q <= mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         occ_q      <= '0;
         s1_valid_q <= 1'b0;
         valid_q    <= 1'b0;
         out_q      <= '0;
         chain_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_cnt_q  <= ram_cnt_d;
         occ_q      <= occ_d;
         s1_valid_q <= s1_valid_d;
         valid_q    <= valid_d;
         out_q      <= out_d;
         chain_q    <= chain_d;
         ovf_q      <= ovf_d;
      end
   end

`ifdef INPUT_BUFFER_DROP_COUNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= 16'h0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign drop_count = drop_cnt_q;
`else
   assign drop_count = 16'h0;
`endif

   assign ready_out   = ready;
   assign valid_out   = valid_q;
   assign eof_out     = out_q[WW-1];
   assign vector_out  = out_q[WW-2:0];
   assign chainId_out = chain_q;
   assign occupancy   = occ_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_input_buffer_mc.sv
// tb/tb_input_buffer_mc.sv - directed self-checking bench for input_buffer_mc
module tb_input_buffer_mc;

   localparam int N   = 8;
   localparam int DW  = 32;
   localparam int DEP = 4;
   localparam int NCH = 3;

`ifdef INPUT_BUFFER_DROP_COUNT_EN
   localparam logic [15:0] EXP_DROP = 16'd1;
`else
   localparam logic [15:0] EXP_DROP = 16'd0;
`endif

   typedef logic [N-1:0][DW-1:0] vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enqueue = 1'b0;
   logic       eof_in = 1'b0;
   logic       deq_ready = 1'b0;
   vec_t       vector_in = '0;
   logic       ready_out, valid_out, eof_out, overflow;
   vec_t       vector_out;
   logic [1:0] chainId_out;
   logic [2:0] occupancy;
   logic [15:0] drop_count;

   int n_cmp = 0;
   int n_bad = 0;

   input_buffer_mc #(.N(N), .DATA_WIDTH(DW), .IB_DEPTH(DEP), .NUM_CHAINS(NCH)) dut (
      .clk(clk), .rst_n(rst_n), .enqueue(enqueue), .eof_in(eof_in),
      .vector_in(vector_in), .ready_out(ready_out), .deq_ready(deq_ready),
      .valid_out(valid_out), .eof_out(eof_out), .vector_out(vector_out),
      .chainId_out(chainId_out), .occupancy(occupancy), .overflow(overflow),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   function automatic vec_t mkvec(input int s);
      vec_t v;
      for (int l = 0; l < N; l++) v[l] = DW'(s * 256 + l) ^ 32'h5A00_0000;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      enqueue = 1'b0; deq_ready = 1'b0; eof_in = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enqueue = 1'b0; deq_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", valid_out); end
      n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL reset_occ got %0d want 0", occupancy); end
      n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", ready_out); end
      n_cmp++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin n_bad++; $display("FAIL reset_ovf got %0b/%0d want 0/0", overflow, drop_count); end
      n_cmp++; if (vector_out !== '0 || eof_out !== 1'b0 || chainId_out !== 2'd0) begin n_bad++; $display("FAIL reset_out got %h/%0b/%0d want 0", vector_out, eof_out, chainId_out); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_entry();
      vec_t a5;
      do_reset();
      for (int l = 0; l < N; l++) a5[l] = 32'hA5;
      enqueue = 1'b1; vector_in = a5; eof_in = 1'b1; deq_ready = 1'b1;
      step();   // edge 0
      enqueue = 1'b0; eof_in = 1'b0;
      n_cmp++; if (valid_out !== 1'b0 || occupancy !== 3'd1) begin n_bad++; $display("FAIL single_e0 got v=%0b occ=%0d want v=0 occ=1", valid_out, occupancy); end
      step();   // edge 1
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL single_e1 got v=%0b want 0", valid_out); end
      step();   // edge 2
      n_cmp++; if (valid_out !== 1'b1 || vector_out !== a5 || eof_out !== 1'b1) begin n_bad++; $display("FAIL single_e2 got v=%0b vec=%h eof=%0b want v=1 A5s eof=1", valid_out, vector_out, eof_out); end
      step();   // edge 3
      n_cmp++; if (valid_out !== 1'b0 || occupancy !== 3'd0) begin n_bad++; $display("FAIL single_e3 got v=%0b occ=%0d want 0/0", valid_out, occupancy); end
   endtask

   task automatic test_fill();
      do_reset();
      deq_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         enqueue = 1'b1; vector_in = mkvec(i + 1); eof_in = (i == 1);
         step();
      end
      enqueue = 1'b0; eof_in = 1'b0;
      step(); step();
      n_cmp++; if (occupancy !== 3'd4 || ready_out !== 1'b0) begin n_bad++; $display("FAIL fill_full got occ=%0d rdy=%0b want 4/0", occupancy, ready_out); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_noovf got %0b want 0", overflow); end
      n_cmp++; if (valid_out !== 1'b1 || vector_out !== mkvec(1)) begin n_bad++; $display("FAIL fill_head got v=%0b vec=%h want 1/%h", valid_out, vector_out, mkvec(1)); end
      enqueue = 1'b1; vector_in = mkvec(99);
      step();
      enqueue = 1'b0;
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill_ovf got %0b want 1", overflow); end
      n_cmp++; if (drop_count !== EXP_DROP) begin n_bad++; $display("FAIL fill_drop got %0d want %0d", drop_count, EXP_DROP); end
      n_cmp++; if (occupancy !== 3'd4) begin n_bad++; $display("FAIL fill_occ_after_drop got %0d want 4", occupancy); end
      step();
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill_sticky got %0b want 1", overflow); end
   endtask

   task automatic test_drain();
      deq_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (valid_out !== 1'b1 || vector_out !== mkvec(i + 1) || eof_out !== (i == 1)) begin
            n_bad++; $display("FAIL drain_%0d got v=%0b vec=%h eof=%0b want v=1 vec=%h eof=%0b", i, valid_out, vector_out, eof_out, mkvec(i + 1), (i == 1));
         end
         step();
      end
      n_cmp++; if (valid_out !== 1'b0 || occupancy !== 3'd0 || ready_out !== 1'b1) begin n_bad++; $display("FAIL drain_empty got v=%0b occ=%0d rdy=%0b want 0/0/1", valid_out, occupancy, ready_out); end
      deq_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int k = 0, gaps = 0, cyc = 0;
      logic [2:0] max_occ = 3'd0;
      do_reset();
      deq_ready = 1'b1;
      while (k < 100 && cyc < 130) begin
         if (cyc < 100) begin enqueue = 1'b1; vector_in = mkvec(1000 + cyc); end
         else enqueue = 1'b0;
         step();
         cyc++;
         if (occupancy > max_occ) max_occ = occupancy;
         if (valid_out === 1'b1) begin
            n_cmp++; if (vector_out !== mkvec(1000 + k)) begin n_bad++; $display("FAIL stream_%0d got %h want %h", k, vector_out, mkvec(1000 + k)); end
            k++;
         end else if (k > 0) gaps++;
      end
      enqueue = 1'b0;
      n_cmp++; if (k != 100) begin n_bad++; $display("FAIL stream_count got %0d want 100", k); end
      n_cmp++; if (gaps != 0) begin n_bad++; $display("FAIL stream_gaps got %0d want 0", gaps); end
      // enqueue edge k, read edge k+1, output edge k+2: three entries in flight
      n_cmp++; if (max_occ > 3'd3) begin n_bad++; $display("FAIL stream_occ got %0d want <=3", max_occ); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL stream_ovf got %0b want 0", overflow); end
      step();
      n_cmp++; if (valid_out !== 1'b0 || occupancy !== 3'd0) begin n_bad++; $display("FAIL stream_end got v=%0b occ=%0d want 0/0", valid_out, occupancy); end
   endtask

   task automatic test_chains();
      int exp_ch [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
      int k = 0, cyc = 0;
      do_reset();
      deq_ready = 1'b1;
      while (k < 8 && cyc < 40) begin
         if (cyc < 8) begin enqueue = 1'b1; vector_in = mkvec(2000 + cyc); eof_in = (cyc % 2 == 1); end
         else begin enqueue = 1'b0; eof_in = 1'b0; end
         step();
         cyc++;
         if (valid_out === 1'b1) begin
            n_cmp++;
            if (chainId_out !== 2'(exp_ch[k]) || eof_out !== (k % 2 == 1) || vector_out !== mkvec(2000 + k)) begin
               n_bad++; $display("FAIL chain_%0d got id=%0d eof=%0b want id=%0d eof=%0b", k, chainId_out, eof_out, exp_ch[k], (k % 2 == 1));
            end
            k++;
         end
      end
      enqueue = 1'b0; eof_in = 1'b0;
      n_cmp++; if (k != 8) begin n_bad++; $display("FAIL chain_count got %0d want 8", k); end
   endtask

   task automatic test_backpressure_reset();
      int sent = 0, got = 0, cyc = 0, exp_chain = 0;
      logic pv, peof;
      vec_t pvec;
      logic [1:0] pch;
      do_reset();
      while (got < 20 && cyc < 400) begin
         if (sent < 20 && ready_out === 1'b1) begin
            enqueue = 1'b1; vector_in = mkvec(3000 + sent); eof_in = (sent % 3 == 2); sent++;
         end else begin
            enqueue = 1'b0; eof_in = 1'b0;
         end
         deq_ready = 1'($urandom_range(0, 1));
         pv = valid_out; pvec = vector_out; peof = eof_out; pch = chainId_out;
         step();
         cyc++;
         if (pv === 1'b1 && deq_ready === 1'b0) begin
            n_cmp++;
            if (valid_out !== 1'b1 || vector_out !== pvec || eof_out !== peof || chainId_out !== pch) begin
               n_bad++; $display("FAIL stall_hold got v=%0b vec=%h want v=1 vec=%h", valid_out, vector_out, pvec);
            end
         end
         if (pv === 1'b1 && deq_ready === 1'b1) begin
            n_cmp++;
            if (pvec !== mkvec(3000 + got) || peof !== (got % 3 == 2) || pch !== 2'(exp_chain)) begin
               n_bad++; $display("FAIL bp_xfer_%0d got vec=%h eof=%0b id=%0d want vec=%h eof=%0b id=%0d", got, pvec, peof, pch, mkvec(3000 + got), (got % 3 == 2), exp_chain);
            end
            if (got % 3 == 2) exp_chain = (exp_chain == NCH - 1) ? 0 : exp_chain + 1;
            got++;
         end
      end
      enqueue = 1'b0; eof_in = 1'b0; deq_ready = 1'b0;
      n_cmp++; if (got != 20 || sent != 20) begin n_bad++; $display("FAIL bp_count got %0d/%0d want 20/20", got, sent); end
      n_cmp++; if (occupancy !== 3'd0 || overflow !== 1'b0) begin n_bad++; $display("FAIL bp_end got occ=%0d ovf=%0b want 0/0", occupancy, overflow); end

      for (int i = 0; i < 3; i++) begin
         enqueue = 1'b1; vector_in = mkvec(4000 + i);
         step();
      end
      enqueue = 1'b0;
      step(); step();
      n_cmp++; if (occupancy !== 3'd3 || valid_out !== 1'b1) begin n_bad++; $display("FAIL held3 got occ=%0d v=%0b want 3/1", occupancy, valid_out); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (valid_out !== 1'b0 || occupancy !== 3'd0 || ready_out !== 1'b1) begin n_bad++; $display("FAIL async_rst got v=%0b occ=%0d rdy=%0b want 0/0/1", valid_out, occupancy, ready_out); end
      @(negedge clk);
      rst_n = 1'b1; deq_ready = 1'b1;
      repeat (4) step();
      n_cmp++; if (valid_out !== 1'b0 || occupancy !== 3'd0) begin n_bad++; $display("FAIL rst_discard got v=%0b occ=%0d want 0/0", valid_out, occupancy); end
   endtask

   initial begin
      test_reset();
      test_single_entry();
      test_fill();
      test_drain();
      test_back_to_back();
      test_chains();
      test_backpressure_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
